// File: rtl/alu_result_stage.sv
// alu_result_stage: flag derivation and SLT fix-up for the adder, behind a 2-entry skid output stage
module alu_result_stage #(
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_result,
  input  logic                 in_sum_msb,
  input  logic                 in_a_msb,
  input  logic                 in_b_msb,
  input  logic                 in_cout,
  input  logic                 in_ctl0,
  input  logic                 in_ctl1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_zero,
  output logic                 out_overflow,
  output logic                 out_cout,
  output logic [OVF_CNT_W-1:0] ovf_count,
  input  logic                 ovf_clear
);
  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        cout;
    logic        vld;
  } ent_t;
  logic                 ovf, in_xfer, out_xfer;
  logic [31:0]          res;
  ent_t                 in_ent, or_q, or_d, sk_q, sk_d;
  logic [OVF_CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    ovf      = (in_ctl0 ^ (in_a_msb == in_b_msb)) && (in_sum_msb != in_a_msb);
    res      = in_ctl1 ? {31'b0, in_sum_msb ^ ovf} : in_result;
    in_ent   = '{res: res, zero: res == 32'b0, ovf: !in_ctl1 && ovf, cout: !in_ctl1 && in_cout, vld: 1'b1};
    in_xfer  = in_valid && in_ready;
    out_xfer = or_q.vld && out_ready;
    or_d     = or_q;
    sk_d     = sk_q;
    if (sk_q.vld && out_xfer) begin
      or_d     = sk_q;
      sk_d.vld = 1'b0;
    end else if (in_xfer && (!or_q.vld || out_xfer)) or_d = in_ent;
    else if (in_xfer) sk_d = in_ent;
    else if (out_xfer) or_d.vld = 1'b0;
    cnt_d = ovf_clear ? '0 : (in_xfer && in_ent.ovf && !(&cnt_q)) ? cnt_q + OVF_CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_q  <= '0;
      sk_q  <= '0;
      cnt_q <= '0;
    end else begin
      or_q  <= or_d;
      sk_q  <= sk_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready     = !sk_q.vld;
  assign out_valid    = or_q.vld;
  assign out_result   = or_q.res;
  assign out_zero     = or_q.zero;
  assign out_overflow = or_q.ovf;
  assign out_cout     = or_q.cout;
  assign ovf_count    = cnt_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random stimulus with an arithmetic reference model and result scoreboard
module tb_alu_result_stage;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_ready;
  logic [31:0] in_result = 0, out_result;
  logic        in_sum_msb = 0, in_a_msb = 0, in_b_msb = 0, in_cout = 0, in_ctl0 = 0, in_ctl1 = 0;
  logic        out_valid, out_ready = 0, out_zero, out_overflow, out_cout, ovf_clear = 0;
  logic [7:0]  ovf_count, m_cnt = 0;
  logic [34:0] q[$];
  logic [34:0] e_vec = 0, held = 0;
  logic        e_ovf = 0, stall_prev = 0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.OVF_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_sum_msb(in_sum_msb), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_cout(in_cout),
    .in_ctl0(in_ctl0), .in_ctl1(in_ctl1), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow), .out_cout(out_cout),
    .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Model the full 32-bit ALU from operands, then present only what the stage sees.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c0, input logic c1);
    logic [32:0] s;
    longint      r;
    logic [31:0] er;
    s     = c0 ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b};
    r     = c0 ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
    e_ovf = !c1 && (r != longint'($signed(r[31:0])));
    er    = c1 ? {31'b0, $signed(a) < $signed(b)} : s[31:0];
    e_vec = {er, er == 32'b0, e_ovf, !c1 && s[32]};
    in_valid = v; in_result = s[31:0]; in_sum_msb = s[31]; in_a_msb = a[31]; in_b_msb = b[31];
    in_cout = s[32]; in_ctl0 = c0; in_ctl1 = c1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c0, input logic c1);
    logic acc;
    drive(1'b1, a, b, c0, c1);
    acc = 0;
    for (int i = 0; i < 16 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 0;
    chk("send_accept", acc, 1);
  endtask

  task automatic drain;
    for (int i = 0; i < 16 && (q.size() > 0 || out_valid); i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      stall_prev = 0;
    end else begin
      checks++;
      assert (ovf_count === m_cnt) else begin
        errors++;
        $error("FAIL ovf_count got %0d exp %0d", ovf_count, m_cnt);
      end
      if (stall_prev) begin
        checks++;
        assert ({out_result, out_zero, out_overflow, out_cout} === held) else begin
          errors++;
          $error("FAIL stall_hold got %0h exp %0h", {out_result, out_zero, out_overflow, out_cout}, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (q.size() > 0 && {out_result, out_zero, out_overflow, out_cout} === q[0]) else begin
          errors++;
          $error("FAIL out_data got %0h exp %0h", {out_result, out_zero, out_overflow, out_cout},
                 q.size() > 0 ? q[0] : 35'bx);
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(e_vec);
        if (e_ovf && m_cnt != 8'hff) m_cnt++;
      end
      if (ovf_clear) m_cnt = 0;
      stall_prev = out_valid && !out_ready;
      held = {out_result, out_zero, out_overflow, out_cout};
    end
  end

  initial begin
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_flags", {out_zero, out_overflow, out_cout}, 0);
    chk("rst_ovf_count", ovf_count, 0);
    rst_n = 1; out_ready = 1;
    send(32'h7fffffff, 32'd1, 0, 0);
    chk("lat_valid", out_valid, 1);
    chk("add_ovf_res", out_result, 32'h80000000);
    chk("add_ovf_flags", {out_zero, out_overflow, out_cout}, 3'b010);
    chk("add_ovf_cnt", ovf_count, 1);
    send(32'd5, 32'd5, 1, 0);
    chk("sub_zero_res", out_result, 0);
    chk("sub_zero_flags", {out_zero, out_overflow, out_cout}, 3'b101);
    ovf_clear = 1;
    send(32'h80000000, 32'd1, 1, 1);
    ovf_clear = 0;
    chk("slt_ovf_res", out_result, 1);
    chk("slt_ovf_flag", out_overflow, 0);
    send(32'd1, 32'd2, 1, 1);
    chk("slt_lt", out_result, 1);
    send(32'd2, 32'd1, 1, 1);
    chk("slt_ge", {out_result, out_zero}, 33'h0_0000_0001);
    ovf_clear = 1;
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 2);
      out_ready = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, op != 0, op == 2);
      tick();
    end
    in_valid = 0; ovf_clear = 0; out_ready = 1;
    drain();
    for (int i = 0; i < 300; i++) send(32'h7fffffff, 32'd1, 0, 0);
    chk("cnt_sat", ovf_count, 255);
    ovf_clear = 1;
    send(32'h7fffffff, 32'd1, 0, 0);
    ovf_clear = 0;
    chk("cnt_clear_prio", ovf_count, 0);
    drain();
    out_ready = 0;
    send(32'd10, 32'd0, 0, 0);
    send(32'd11, 32'd0, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_result, 10);
    drive(1'b1, 32'd12, 32'd0, 0, 0);
    tick(); tick();
    chk("bp_still_full", in_ready, 0);
    out_ready = 1;
    send(32'd12, 32'd0, 0, 0);
    send(32'd13, 32'd0, 0, 0);
    drain();
    out_ready = 0;
    send(32'd20, 32'd0, 0, 0);
    send(32'd21, 32'd0, 0, 0);
    chk("full_before_rst", in_ready, 0);
    rst_n = 0;
    drive(1'b1, 32'h7fffffff, 32'd1, 0, 0);
    tick();
    chk("rst_full_valid", out_valid, 0);
    chk("rst_full_ready", in_ready, 1);
    chk("rst_full_outs", {out_result, out_zero, out_overflow, out_cout}, 0);
    chk("rst_full_cnt", ovf_count, 0);
    in_valid = 0; rst_n = 1;
    tick();
    chk("post_rst_valid", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage placed directly downstream of the 32-bit adder/subtractor. Each cycle it accepts one raw adder result with its operand sign bits and op controls, and derives the Zero and signed Overflow flags. It also corrects the SLT bit for signed overflow and presents result plus flags on a valid/ready interface. A 2-entry skid buffer decouples the combinational ALU from a stalling consumer, and a saturating counter records overflow events.

## Interface
Parameters:
- `OVF_CNT_W`, 8: width of overflow event counter.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  stage can accept; equals skid entry empty.
- `in_result`  in  32  adder/subtractor `out` (for SLT only bit 0 meaningful).
- `in_sum_msb`  in  1  raw adder sum bit 31, pre-SLT mux.
- `in_a_msb`  in  1  operand A bit 31.
- `in_b_msb`  in  1  operand B bit 31, un-inverted.
- `in_cout`  in  1  adder carry out.
- `in_ctl0`  in  1  1 = SUB/SLT, 0 = ADD.
- `in_ctl1`  in  1  1 = SLT.
- `out_valid`  out  1  output register holds a result.
- `out_ready`  in  1  consumer accepts this cycle.
- `out_result`  out  32  final result.
- `out_zero`, `out_overflow`, `out_cout`  out  1 each  flags for `out_result`.
- `ovf_count`  out  OVF_CNT_W  saturating count of accepted results with overflow=1.
- `ovf_clear`  in  1  synchronous clear of `ovf_count`.

## Operation
- Derivation (combinational on inputs, before any storage):
  - `ovf` = ADD (ctl0=0): `a_msb==b_msb && sum_msb!=a_msb`; SUB/SLT (ctl0=1): `a_msb!=b_msb && sum_msb!=a_msb`.
  - ctl1=1 (SLT): result = {31'b0, sum_msb ^ ovf}; overflow flag = 0; cout flag = 0.
  - ctl1=0: result = `in_result`; overflow flag = `ovf`; cout flag = `in_cout`.
  - zero = (derived result == 0).
  - ctl0=0, ctl1=1 is illegal. Treat it as SLT; no error is raised.
- Storage: output register (OR) plus one skid register (SK), each holding {result, zero, overflow, cout, valid}.
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- States by (OR.valid, SK.valid):
  - EMPTY (0,0): transfer in loads OR -> ONE.
  - ONE (1,0):
    - in and out together: OR reloads, stays ONE.
    - out only -> EMPTY.
    - in only: new data to SK -> FULL.
  - FULL (1,1): `in_ready`=0.
    - Out transfer: SK moves to OR, SK empties -> ONE.
    - Input ignored while not ready.
- Ordering strictly FIFO; no result dropped or duplicated.
- `ovf_count` increments on each transfer in whose derived overflow = 1. It saturates at all-ones.
  - `ovf_clear` has priority. Clear and increment in the same cycle gives 0.

## Timing
- Latency: in transfer at edge N with stage EMPTY puts data on outputs after edge N; `out_valid`=1 in cycle N+1.
- Throughput 1 per cycle while `out_ready`=1.
- `in_ready` is a registered function of SK.valid only. No combinational path from `out_ready` to `in_ready`.
- Outputs are registered; `out_*` stable while `out_valid && !out_ready`.
- Reset (`rst_n`=0 at an edge): OR.valid=SK.valid=0, `out_valid`=0, `in_ready`=1, `out_result`=0, `out_zero`=0, `out_overflow`=0, `out_cout`=0, `ovf_count`=0.
  - Reset mid-transfer discards all held results.
  - Inputs on the reset edge are ignored.

## Test plan
- ADD, A=0x7FFFFFFF, B=1: raw 0x80000000, cout 0 -> result 0x80000000, overflow=1, zero=0, cout=0, ovf_count=1.
- SUB, A=5, B=5: raw 0, cout 1 -> result 0, zero=1, overflow=0, cout=1.
- SLT, A=0x80000000, B=1: raw sum 0x7FFFFFFF, sum_msb=0, ovf=1 -> result 1, overflow flag 0. SLT, A=1, B=2 -> result 1; A=2, B=1 -> result 0.
- Backpressure: stream 4 results with `out_ready` held 0. Expected: results 1 and 2 accepted, `in_ready`=0 after the second. Raise `out_ready`: all 4 emerge in order, 1 per cycle, none lost.
- Counter: 300 overflowing ADDs with OVF_CNT_W=8 -> `ovf_count`=255. Pulse `ovf_clear` with a concurrent overflow transfer -> 0.
- Assert `rst_n`=0 while FULL -> next cycle `out_valid`=0, `in_ready`=1, all outputs 0.
